// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates conditional branches in EX and raises mispredict redirects.
// The BHT predictor (2-bit counters) is built only when BRANCH_BHT_EN is defined; otherwise fetch predicts not-taken.
module branch_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic [2:0]        ex_fun3,
    input  logic [XLEN-1:0]   ex_op1,
    input  logic [XLEN-1:0]   ex_op2,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              ex_pred_taken,
    output logic              taken,
    output logic              flush,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              illegal_br,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int unsigned IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    logic              r_flush;
    logic [XLEN-1:0]   r_redirect_pc;
    logic              r_illegal_br;
    logic [CNT_W-1:0]  r_br_cnt;
    logic [CNT_W-1:0]  r_mispred_cnt;

    logic              w_resolve;
    logic              w_legal;
    logic              w_cond;
    logic              w_event;
    logic              w_mispred;
    logic              w_unused;

    // EX inputs in the flush cycle belong to the wrong path
    assign w_resolve = ex_valid & ex_branch & ~r_flush;

    // Branch condition decode
    always_comb begin
        w_cond  = 1'b0;
        w_legal = 1'b1;
        case (ex_fun3)
            3'b000:  w_cond = (ex_op1 == ex_op2);
            3'b001:  w_cond = (ex_op1 != ex_op2);
            3'b100:  w_cond = ($signed(ex_op1) <  $signed(ex_op2));
            3'b101:  w_cond = ($signed(ex_op1) >= $signed(ex_op2));
            3'b110:  w_cond = (ex_op1 <  ex_op2);
            3'b111:  w_cond = (ex_op1 >= ex_op2);
            default: w_legal = 1'b0;
        endcase
    end

    assign w_event   = w_resolve & w_legal;
    assign taken     = w_event & w_cond;
    assign w_mispred = w_event & (w_cond != ex_pred_taken);

    // Redirect, illegal pulse and saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_illegal_br  <= 1'b0;
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_flush      <= w_mispred;
            r_illegal_br <= w_resolve & ~w_legal;
            if (w_mispred) begin
                r_redirect_pc <= w_cond ? ex_target : ex_pc + XLEN'(4);
            end
            if (w_event && (r_br_cnt != {CNT_W{1'b1}})) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (w_mispred && (r_mispred_cnt != {CNT_W{1'b1}})) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign flush       = r_flush;
    assign redirect_pc = r_redirect_pc;
    assign illegal_br  = r_illegal_br;
    assign br_cnt      = r_br_cnt;
    assign mispred_cnt = r_mispred_cnt;

`ifdef BRANCH_BHT_EN
    logic [1:0]       r_bht [BHT_DEPTH];
    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];

    // 2-bit saturating counters; lookup reads the pre-update value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_event) begin
            if (w_cond && (r_bht[w_ex_idx] != 2'b11)) begin
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'd1;
            end else if (!w_cond && (r_bht[w_ex_idx] != 2'b00)) begin
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'd1;
            end
        end
    end

    assign if_pred_taken = r_bht[w_if_idx][1];
`else
    assign if_pred_taken = 1'b0;
`endif

    assign w_unused = ^if_pc;

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit (CNT_W=4 so counter saturation is reachable).
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_branch;
    logic [2:0]  ex_fun3;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        taken;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        illegal_br;
    logic [3:0]  br_cnt;
    logic [3:0]  mispred_cnt;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef BRANCH_BHT_EN
    localparam logic BHT_ON = 1'b1;
`else
    localparam logic BHT_ON = 1'b0;
`endif

    branch_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_fun3(ex_fun3),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .taken(taken), .flush(flush),
        .redirect_pc(redirect_pc), .illegal_br(illegal_br),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        ex_valid = 1'b1; ex_branch = 1'b1; ex_fun3 = f3;
        ex_op1 = a; ex_op2 = b; ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_fun3 = 3'b000;
        ex_op1 = '0; ex_op2 = '0; ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); if_pc = 32'h40;
        #2;
        n_chk++; if (if_pred_taken !== 1'b0) $display("FAIL rst_pred: got %h want 0", if_pred_taken); else n_pass++;
        n_chk++; if (taken !== 1'b0) $display("FAIL rst_taken: got %h want 0", taken); else n_pass++;
        n_chk++; if (flush !== 1'b0) $display("FAIL rst_flush: got %h want 0", flush); else n_pass++;
        n_chk++; if (redirect_pc !== 32'h0) $display("FAIL rst_redirect: got %h want 0", redirect_pc); else n_pass++;
        n_chk++; if (illegal_br !== 1'b0) $display("FAIL rst_illegal: got %h want 0", illegal_br); else n_pass++;
        n_chk++; if ({br_cnt, mispred_cnt} !== 8'h00) $display("FAIL rst_cnts: got %h want 00", {br_cnt, mispred_cnt}); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        step();
    endtask

    task automatic test_signed();
        set_br(3'b000, 32'd5, 32'd5, 32'h10, 32'h50, 1'b1);
        #1;
        n_chk++; if (taken !== 1'b1) $display("FAIL beq_taken: got %h want 1", taken); else n_pass++;
        step();
        n_chk++; if (flush !== 1'b0) $display("FAIL beq_flush: got %h want 0", flush); else n_pass++;
        n_chk++; if (br_cnt !== 4'd1) $display("FAIL beq_brcnt: got %h want 1", br_cnt); else n_pass++;
        set_br(3'b100, 32'hFFFFFFFF, 32'd1, 32'h80, 32'h200, 1'b0);
        #1;
        n_chk++; if (taken !== 1'b1) $display("FAIL blt_taken: got %h want 1", taken); else n_pass++;
        step();
        idle();
        n_chk++; if (flush !== 1'b1) $display("FAIL blt_flush: got %h want 1", flush); else n_pass++;
        n_chk++; if (redirect_pc !== 32'h200) $display("FAIL blt_redirect: got %h want 200", redirect_pc); else n_pass++;
        n_chk++; if ({br_cnt, mispred_cnt} !== 8'h21) $display("FAIL blt_cnts: got %h want 21", {br_cnt, mispred_cnt}); else n_pass++;
        step();
        n_chk++; if (flush !== 1'b0) $display("FAIL blt_flush_pulse: got %h want 0", flush); else n_pass++;
    endtask

    task automatic test_unsigned();
        set_br(3'b110, 32'hFFFFFFFF, 32'd1, 32'h84, 32'h300, 1'b1);
        #1;
        n_chk++; if (taken !== 1'b0) $display("FAIL bltu_taken: got %h want 0", taken); else n_pass++;
        step();
        idle();
        n_chk++; if (flush !== 1'b1) $display("FAIL bltu_flush: got %h want 1", flush); else n_pass++;
        n_chk++; if (redirect_pc !== 32'h88) $display("FAIL bltu_redirect: got %h want 88", redirect_pc); else n_pass++;
        n_chk++; if ({br_cnt, mispred_cnt} !== 8'h32) $display("FAIL bltu_cnts: got %h want 32", {br_cnt, mispred_cnt}); else n_pass++;
        step();
        set_br(3'b000, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h10, 1'b1);
        step();
        idle();
        n_chk++; if (flush !== 1'b1) $display("FAIL wrap_flush: got %h want 1", flush); else n_pass++;
        n_chk++; if (redirect_pc !== 32'h0) $display("FAIL wrap_redirect: got %h want 0", redirect_pc); else n_pass++;
        n_chk++; if ({br_cnt, mispred_cnt} !== 8'h43) $display("FAIL wrap_cnts: got %h want 43", {br_cnt, mispred_cnt}); else n_pass++;
        step();
    endtask

    task automatic test_bht();
        if_pc = 32'h100;
        for (int i = 0; i < 4; i++) begin
            set_br(3'b000, 32'd7, 32'd7, 32'h100, 32'h500, 1'b1);
            #1;
            n_chk++;
            if (if_pred_taken !== (BHT_ON && (i > 0)))
                $display("FAIL bht_pred_%0d: got %h want %h", i, if_pred_taken, (BHT_ON && (i > 0)));
            else n_pass++;
            step();
        end
        idle();
        n_chk++; if (if_pred_taken !== BHT_ON) $display("FAIL bht_final: got %h want %h", if_pred_taken, BHT_ON); else n_pass++;
        n_chk++; if ({br_cnt, mispred_cnt, flush} !== 9'b1000_0011_0) $display("FAIL bht_cnts: got %h want 106", {br_cnt, mispred_cnt, flush}); else n_pass++;
    endtask

    task automatic test_flush_ignore();
        if_pc = 32'h20;
        set_br(3'b000, 32'd9, 32'd9, 32'h20, 32'h400, 1'b0);
        step();
        n_chk++; if (flush !== 1'b1) $display("FAIL fi_flush: got %h want 1", flush); else n_pass++;
        n_chk++; if (redirect_pc !== 32'h400) $display("FAIL fi_redirect: got %h want 400", redirect_pc); else n_pass++;
        n_chk++; if ({br_cnt, mispred_cnt} !== 8'h94) $display("FAIL fi_cnts: got %h want 94", {br_cnt, mispred_cnt}); else n_pass++;
        set_br(3'b000, 32'd1, 32'd2, 32'h20, 32'h400, 1'b1);
        #1;
        n_chk++; if (taken !== 1'b0) $display("FAIL fi_taken: got %h want 0", taken); else n_pass++;
        step();
        idle();
        n_chk++; if (flush !== 1'b0) $display("FAIL fi_noflush: got %h want 0", flush); else n_pass++;
        n_chk++; if ({br_cnt, mispred_cnt} !== 8'h94) $display("FAIL fi_cnts_hold: got %h want 94", {br_cnt, mispred_cnt}); else n_pass++;
        n_chk++; if (if_pred_taken !== BHT_ON) $display("FAIL fi_bht_hold: got %h want %h", if_pred_taken, BHT_ON); else n_pass++;
    endtask

    task automatic test_illegal();
        set_br(3'b010, 32'd3, 32'd3, 32'h30, 32'h600, 1'b1);
        #1;
        n_chk++; if (taken !== 1'b0) $display("FAIL ill_taken: got %h want 0", taken); else n_pass++;
        step();
        idle();
        n_chk++; if (illegal_br !== 1'b1) $display("FAIL ill_pulse: got %h want 1", illegal_br); else n_pass++;
        n_chk++; if (flush !== 1'b0) $display("FAIL ill_flush: got %h want 0", flush); else n_pass++;
        n_chk++; if ({br_cnt, mispred_cnt} !== 8'h94) $display("FAIL ill_cnts: got %h want 94", {br_cnt, mispred_cnt}); else n_pass++;
        step();
        n_chk++; if (illegal_br !== 1'b0) $display("FAIL ill_clear: got %h want 0", illegal_br); else n_pass++;
    endtask

    task automatic test_no_event();
        set_br(3'b000, 32'd4, 32'd4, 32'h60, 32'h700, 1'b0);
        ex_valid = 1'b0;
        #1;
        n_chk++; if (taken !== 1'b0) $display("FAIL ne_taken_nv: got %h want 0", taken); else n_pass++;
        step();
        ex_valid = 1'b1; ex_branch = 1'b0;
        #1;
        n_chk++; if (taken !== 1'b0) $display("FAIL ne_taken_nb: got %h want 0", taken); else n_pass++;
        step();
        idle();
        n_chk++; if ({br_cnt, mispred_cnt, flush} !== 9'b1001_0100_0) $display("FAIL ne_hold: got %h want 128", {br_cnt, mispred_cnt, flush}); else n_pass++;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 8; i++) begin
            set_br(3'b001, 32'd1, 32'd2, 32'h200, 32'h800, 1'b1);
            step();
            if (i == 5) begin
                n_chk++; if (br_cnt !== 4'hF) $display("FAIL sat_reach: got %h want f", br_cnt); else n_pass++;
            end
        end
        idle();
        n_chk++; if (br_cnt !== 4'hF) $display("FAIL sat_hold: got %h want f", br_cnt); else n_pass++;
        n_chk++; if (mispred_cnt !== 4'h4) $display("FAIL sat_mispred: got %h want 4", mispred_cnt); else n_pass++;
    endtask

    task automatic test_reset_mispred();
        if_pc = 32'h20;
        @(negedge clk);
        set_br(3'b000, 32'd8, 32'd8, 32'h40, 32'h900, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if ({br_cnt, mispred_cnt} !== 8'h00) $display("FAIL rm_cnts: got %h want 00", {br_cnt, mispred_cnt}); else n_pass++;
        n_chk++; if (if_pred_taken !== 1'b0) $display("FAIL rm_bht_reset: got %h want 0", if_pred_taken); else n_pass++;
        step();
        idle();
        @(negedge clk); rst_n = 1'b1;
        step();
        n_chk++; if (flush !== 1'b0) $display("FAIL rm_flush: got %h want 0", flush); else n_pass++;
        n_chk++; if (redirect_pc !== 32'h0) $display("FAIL rm_redirect: got %h want 0", redirect_pc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_bht();
        test_flush_ignore();
        test_illegal();
        test_no_event();
        test_saturate();
        test_reset_mispred();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
